// File: rtl/axi_lite_chk_pkg.sv
// rtl/axi_lite_chk_pkg.sv - shared constants, FSM encoding and LFSR step for the register sweep checker
package axi_lite_chk_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Galois feedback taps, applied after a right shift when the outgoing bit is 1
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_NEXT,
        S_FIN
    } chk_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/axi_lite_pattern_lfsr.sv
// rtl/axi_lite_pattern_lfsr.sv - 32-bit Galois LFSR pattern source with load and step
module axi_lite_pattern_lfsr
    import axi_lite_chk_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0101FFFF
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    // Load restarts the sequence at SEED; step advances one LFSR position
    always_ff @(posedge ACLK) begin
        if (ARESET || load) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/axi_lite_reg_sweep_checker.sv
// rtl/axi_lite_reg_sweep_checker.sv - AXI4-Lite master that writes, reads back and checks a register bank
module axi_lite_reg_sweep_checker
    import axi_lite_chk_pkg::*;
#(
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          NUM_REGS     = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h43C00000,
    parameter logic [31:0] PATTERN_SEED = 32'h0101FFFF,
    parameter logic [31:0] CMP_MASK     = 32'hFFFFFFFF,
    parameter int          TIMEOUT_CYC  = 1024,
    parameter int          ERR_W        = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_W-1:0]      err_count,
    output logic [7:0]            first_err_idx,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_REGS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    chk_state_t        state;
    logic              mode_q;
    logic              rd_phase;
    logic [7:0]        idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [31:0]       pattern;
    logic [ADDR_W-1:0] addr;

    logic aw_left, w_left, step_done, wait_state, tmo_hit, resp_err, err_event;
    logic last_idx, wr_phase_end, lfsr_load, lfsr_step;

    axi_lite_pattern_lfsr #(
        .SEED (PATTERN_SEED)
    ) u_lfsr (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .load   (lfsr_load),
        .step   (lfsr_step),
        .value  (pattern)
    );

    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARADDR = addr;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = pattern;
    assign M_AXI_WSTRB  = '1;

    // Handshake completion, timeout and error detection for the current state
    always_comb begin
        aw_left      = M_AXI_AWVALID && !M_AXI_AWREADY;
        w_left       = M_AXI_WVALID && !M_AXI_WREADY;
        step_done    = 1'b0;
        case (state)
            S_WR_REQ:  step_done = !aw_left && !w_left;
            S_WR_RESP: step_done = M_AXI_BVALID;
            S_RD_REQ:  step_done = M_AXI_ARREADY;
            S_RD_DATA: step_done = M_AXI_RVALID;
            default:   step_done = 1'b0;
        endcase
        wait_state   = state inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA};
        tmo_hit      = wait_state && !step_done && (tmo_cnt == TMO_LAST);
        resp_err     = 1'b0;
        if (state == S_WR_RESP && M_AXI_BVALID && M_AXI_BRESP != RESP_OKAY) begin
            resp_err = 1'b1;
        end
        if (state == S_RD_DATA && M_AXI_RVALID &&
            (M_AXI_RRESP != RESP_OKAY || ((M_AXI_RDATA ^ pattern) & CMP_MASK) != '0)) begin
            resp_err = 1'b1;
        end
        err_event    = resp_err || tmo_hit;
        last_idx     = (idx == LAST_IDX);
        wr_phase_end = (state == S_NEXT) && mode_q && !rd_phase && last_idx;
        lfsr_load    = ((state == S_IDLE) && start) || wr_phase_end;
        lfsr_step    = (state == S_NEXT) && !last_idx;
        addr         = ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 2'b00});
    end

    // Sweep sequencer with registered channel handshakes and status
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            rd_phase      <= 1'b0;
            idx           <= '0;
            tmo_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            done    <= 1'b0;
            tmo_cnt <= tmo_cnt + 1'b1;
            if (err_event) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 1'b1;
                end
                if (err_count == '0) begin
                    first_err_idx <= idx;
                end
            end
            if (tmo_hit) begin
                timeout       <= 1'b1;
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                tmo_cnt       <= '0;
                state         <= S_FIN;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mode_q        <= mode;
                            rd_phase      <= 1'b0;
                            idx           <= '0;
                            err_count     <= '0;
                            first_err_idx <= '0;
                            timeout       <= 1'b0;
                            pass          <= 1'b0;
                            busy          <= 1'b1;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            tmo_cnt       <= '0;
                            state         <= S_WR_REQ;
                        end
                    end
                    S_WR_REQ: begin
                        if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                        if (step_done) begin
                            M_AXI_BREADY <= 1'b1;
                            tmo_cnt      <= '0;
                            state        <= S_WR_RESP;
                        end
                    end
                    S_WR_RESP: begin
                        if (M_AXI_BVALID) begin
                            M_AXI_BREADY <= 1'b0;
                            tmo_cnt      <= '0;
                            if (mode_q) begin
                                state <= S_NEXT;
                            end else begin
                                M_AXI_ARVALID <= 1'b1;
                                state         <= S_RD_REQ;
                            end
                        end
                    end
                    S_RD_REQ: begin
                        if (M_AXI_ARREADY) begin
                            M_AXI_ARVALID <= 1'b0;
                            M_AXI_RREADY  <= 1'b1;
                            tmo_cnt       <= '0;
                            state         <= S_RD_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (M_AXI_RVALID) begin
                            M_AXI_RREADY <= 1'b0;
                            tmo_cnt      <= '0;
                            state        <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        tmo_cnt <= '0;
                        if (wr_phase_end) begin
                            idx           <= '0;
                            rd_phase      <= 1'b1;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_REQ;
                        end else if (last_idx) begin
                            state <= S_FIN;
                        end else begin
                            idx <= idx + 1'b1;
                            if (mode_q && rd_phase) begin
                                M_AXI_ARVALID <= 1'b1;
                                state         <= S_RD_REQ;
                            end else begin
                                M_AXI_AWVALID <= 1'b1;
                                M_AXI_WVALID  <= 1'b1;
                                state         <= S_WR_REQ;
                            end
                        end
                    end
                    S_FIN: begin
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !timeout;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_sweep_checker.sv
// tb/tb_axi_lite_reg_sweep_checker.sv - directed bench for the register sweep checker with RAM slave models
module tb_axi_lite_reg_sweep_checker;

    logic tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    // index 0: NUM_REGS=4, full compare mask; index 1: NUM_REGS=8, bit 0 masked
    logic        areset [2];
    logic        start [2];
    logic        mode [2];
    logic        busy [2], done [2], pass [2], timeout [2];
    logic [7:0]  err_count [2], first_err_idx [2];
    logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
    logic [2:0]  awprot [2], arprot [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2], rvalid [2], rready [2];

    // slave model state and controls
    logic [31:0] mem [2][8];
    logic        aw_got [2], w_got [2], rstall [2];
    int          aw_idx [2];
    logic [31:0] w_data [2], first_awaddr [2], first_wdata [2], corrupt_mask [2];
    int          aw_cnt [2], w_cnt [2], ar_cnt [2], aw_at_ar [2];
    int          berr_idx [2], rerr_idx [2], corrupt_idx [2];

    logic [31:0] pat [8] = '{32'h0101FFFF, 32'h80A0FFFC, 32'h40507FFE, 32'h20283FFF,
                             32'h90341FFC, 32'h481A0FFE, 32'h240D07FF, 32'h922683FC};

    int passed = 0;
    int total  = 0;

    axi_lite_reg_sweep_checker #(
        .NUM_REGS (4), .CMP_MASK (32'hFFFFFFFF), .TIMEOUT_CYC (16)
    ) u_dut0 (
        .ACLK (tb_ACLK), .ARESET (areset[0]), .start (start[0]), .mode (mode[0]),
        .busy (busy[0]), .done (done[0]), .pass (pass[0]), .timeout (timeout[0]),
        .err_count (err_count[0]), .first_err_idx (first_err_idx[0]),
        .M_AXI_AWADDR (awaddr[0]), .M_AXI_AWPROT (awprot[0]), .M_AXI_AWVALID (awvalid[0]),
        .M_AXI_AWREADY (awready[0]), .M_AXI_WDATA (wdata[0]), .M_AXI_WSTRB (wstrb[0]),
        .M_AXI_WVALID (wvalid[0]), .M_AXI_WREADY (wready[0]), .M_AXI_BRESP (bresp[0]),
        .M_AXI_BVALID (bvalid[0]), .M_AXI_BREADY (bready[0]), .M_AXI_ARADDR (araddr[0]),
        .M_AXI_ARPROT (arprot[0]), .M_AXI_ARVALID (arvalid[0]), .M_AXI_ARREADY (arready[0]),
        .M_AXI_RDATA (rdata[0]), .M_AXI_RRESP (rresp[0]), .M_AXI_RVALID (rvalid[0]),
        .M_AXI_RREADY (rready[0])
    );

    axi_lite_reg_sweep_checker #(
        .NUM_REGS (8), .CMP_MASK (32'hFFFFFFFE), .TIMEOUT_CYC (16)
    ) u_dut1 (
        .ACLK (tb_ACLK), .ARESET (areset[1]), .start (start[1]), .mode (mode[1]),
        .busy (busy[1]), .done (done[1]), .pass (pass[1]), .timeout (timeout[1]),
        .err_count (err_count[1]), .first_err_idx (first_err_idx[1]),
        .M_AXI_AWADDR (awaddr[1]), .M_AXI_AWPROT (awprot[1]), .M_AXI_AWVALID (awvalid[1]),
        .M_AXI_AWREADY (awready[1]), .M_AXI_WDATA (wdata[1]), .M_AXI_WSTRB (wstrb[1]),
        .M_AXI_WVALID (wvalid[1]), .M_AXI_WREADY (wready[1]), .M_AXI_BRESP (bresp[1]),
        .M_AXI_BVALID (bvalid[1]), .M_AXI_BREADY (bready[1]), .M_AXI_ARADDR (araddr[1]),
        .M_AXI_ARPROT (arprot[1]), .M_AXI_ARVALID (arvalid[1]), .M_AXI_ARREADY (arready[1]),
        .M_AXI_RDATA (rdata[1]), .M_AXI_RRESP (rresp[1]), .M_AXI_RVALID (rvalid[1]),
        .M_AXI_RREADY (rready[1])
    );

    function automatic int slot(input logic [31:0] a);
        return int'((a - 32'h43C00000) >> 2) & 7;
    endfunction

    function automatic logic [24:0] outs(input int k);
        return {busy[k], done[k], pass[k], timeout[k], err_count[k], first_err_idx[k],
                awvalid[k], wvalid[k], bready[k], arvalid[k], rready[k]};
    endfunction

    // RAM slave: B one cycle after both AW and W are captured, R one cycle after AR
    always @(posedge tb_ACLK) begin
        for (int k = 0; k < 2; k++) begin
            if (areset[k]) begin
                aw_got[k] <= 1'b0; w_got[k] <= 1'b0; bvalid[k] <= 1'b0; rvalid[k] <= 1'b0;
                bresp[k] <= 2'b00; rresp[k] <= 2'b00; rdata[k] <= '0; aw_idx[k] <= 0;
                aw_cnt[k] <= 0; w_cnt[k] <= 0; ar_cnt[k] <= 0; aw_at_ar[k] <= -1;
                first_awaddr[k] <= '0; first_wdata[k] <= '0;
                for (int i = 0; i < 8; i++) mem[k][i] <= '0;
            end else begin
                if (awvalid[k] && awready[k]) begin
                    aw_got[k] <= 1'b1;
                    aw_idx[k] <= slot(awaddr[k]);
                    aw_cnt[k] <= aw_cnt[k] + 1;
                    if (aw_cnt[k] == 0) first_awaddr[k] <= awaddr[k];
                end
                if (wvalid[k] && wready[k]) begin
                    w_got[k]  <= 1'b1;
                    w_data[k] <= wdata[k];
                    w_cnt[k]  <= w_cnt[k] + 1;
                    if (w_cnt[k] == 0) first_wdata[k] <= wdata[k];
                end
                if (aw_got[k] && w_got[k] && !bvalid[k]) begin
                    mem[k][aw_idx[k]] <= w_data[k];
                    bvalid[k] <= 1'b1;
                    bresp[k]  <= (aw_idx[k] == berr_idx[k]) ? 2'b10 : 2'b00;
                end
                if (bvalid[k] && bready[k]) begin
                    bvalid[k] <= 1'b0; aw_got[k] <= 1'b0; w_got[k] <= 1'b0;
                end
                if (arvalid[k] && arready[k]) begin
                    ar_cnt[k] <= ar_cnt[k] + 1;
                    if (ar_cnt[k] == 0) aw_at_ar[k] <= aw_cnt[k];
                    if (!rstall[k]) begin
                        rvalid[k] <= 1'b1;
                        rdata[k]  <= mem[k][slot(araddr[k])] ^
                                     ((slot(araddr[k]) == corrupt_idx[k]) ? corrupt_mask[k] : 32'h0);
                        rresp[k]  <= (slot(araddr[k]) == rerr_idx[k]) ? 2'b10 : 2'b00;
                    end
                end
                if (rvalid[k] && rready[k]) rvalid[k] <= 1'b0;
            end
        end
    end

    task automatic do_reset(input int k);
        @(negedge tb_ACLK);
        areset[k] = 1'b1; start[k] = 1'b0; mode[k] = 1'b0;
        awready[k] = 1'b1; wready[k] = 1'b1; arready[k] = 1'b1; rstall[k] = 1'b0;
        berr_idx[k] = -1; rerr_idx[k] = -1; corrupt_idx[k] = -1; corrupt_mask[k] = '0;
        repeat (2) @(negedge tb_ACLK);
        areset[k] = 1'b0;
    endtask

    task automatic pulse_start(input int k, input logic m);
        @(negedge tb_ACLK);
        start[k] = 1'b1; mode[k] = m;
        @(negedge tb_ACLK);
        start[k] = 1'b0; mode[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < 400 && !ok) begin
            if (done[k]) ok = 1'b1;
            else begin @(negedge tb_ACLK); n++; end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (outs(k) !== 25'h0) $display("FAIL reset_outs[%0d]: got %h expected 0", k, outs(k));
            else passed++;
            total++;
            if ({awprot[k], arprot[k], wstrb[k]} !== 10'h00F)
                $display("FAIL reset_prot_strb[%0d]: got %h expected 00f", k, {awprot[k], arprot[k], wstrb[k]});
            else passed++;
        end
    endtask

    task automatic test_basic();
        int n; bit ok;
        do_reset(0);
        pulse_start(0, 1'b0);
        wait_done(0, n, ok);
        total++; if (!ok) $display("FAIL basic_done: no done within 400 cycles"); else passed++;
        total++; if (pass[0] !== 1'b1) $display("FAIL basic_pass: got %b expected 1", pass[0]); else passed++;
        total++; if (err_count[0] !== 8'd0) $display("FAIL basic_err: got %0d expected 0", err_count[0]); else passed++;
        total++;
        if (first_awaddr[0] !== 32'h43C00000) $display("FAIL basic_addr0: got %h expected 43c00000", first_awaddr[0]);
        else passed++;
        total++;
        if (first_wdata[0] !== 32'h0101FFFF) $display("FAIL basic_data0: got %h expected 0101ffff", first_wdata[0]);
        else passed++;
        for (int i = 1; i < 4; i++) begin
            total++;
            if (mem[0][i] !== pat[i]) $display("FAIL basic_pat[%0d]: got %h expected %h", i, mem[0][i], pat[i]);
            else passed++;
        end
        total++;
        if (aw_cnt[0] !== 4 || ar_cnt[0] !== 4) $display("FAIL basic_counts: got aw %0d ar %0d expected 4 4", aw_cnt[0], ar_cnt[0]);
        else passed++;
        @(negedge tb_ACLK);
        total++;
        if ({done[0], busy[0]} !== 2'b00) $display("FAIL basic_done_pulse: got %b expected 00", {done[0], busy[0]});
        else passed++;
    endtask

    task automatic test_corrupt();
        int n; bit ok;
        do_reset(0);
        corrupt_idx[0] = 2; corrupt_mask[0] = 32'h1;
        pulse_start(0, 1'b0);
        wait_done(0, n, ok);
        total++;
        if (!ok || {pass[0], err_count[0], first_err_idx[0]} !== {1'b0, 8'd1, 8'd2})
            $display("FAIL corrupt_full_mask: got done %b pass %b err %0d idx %0d expected 1 0 1 2", ok, pass[0], err_count[0], first_err_idx[0]);
        else passed++;
        do_reset(1);
        corrupt_idx[1] = 2; corrupt_mask[1] = 32'h1;
        pulse_start(1, 1'b0);
        wait_done(1, n, ok);
        total++;
        if (!ok || {pass[1], err_count[1]} !== {1'b1, 8'd0})
            $display("FAIL corrupt_masked_bit0: got done %b pass %b err %0d expected 1 1 0", ok, pass[1], err_count[1]);
        else passed++;
        do_reset(1);
        corrupt_idx[1] = 5; corrupt_mask[1] = 32'h2;
        pulse_start(1, 1'b0);
        wait_done(1, n, ok);
        total++;
        if (!ok || {pass[1], err_count[1], first_err_idx[1]} !== {1'b0, 8'd1, 8'd5})
            $display("FAIL corrupt_masked_bit1: got done %b pass %b err %0d idx %0d expected 1 0 1 5", ok, pass[1], err_count[1], first_err_idx[1]);
        else passed++;
    endtask

    task automatic test_mode1();
        int n; bit ok;
        do_reset(1);
        pulse_start(1, 1'b1);
        wait_done(1, n, ok);
        total++; if (!ok) $display("FAIL mode1_done: no done within 400 cycles"); else passed++;
        total++;
        if (aw_at_ar[1] !== 8) $display("FAIL mode1_aw_before_ar: got %0d expected 8", aw_at_ar[1]); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[1][i] !== pat[i]) $display("FAIL mode1_pat[%0d]: got %h expected %h", i, mem[1][i], pat[i]);
            else passed++;
        end
        total++;
        if ({pass[1], err_count[1], ar_cnt[1]} !== {1'b1, 8'd0, 32'd8})
            $display("FAIL mode1_result: got pass %b err %0d ar %0d expected 1 0 8", pass[1], err_count[1], ar_cnt[1]);
        else passed++;
    endtask

    task automatic test_resp_err();
        int n; bit ok;
        do_reset(0);
        berr_idx[0] = 1; rerr_idx[0] = 3;
        pulse_start(0, 1'b0);
        wait_done(0, n, ok);
        total++;
        if (!ok || {pass[0], err_count[0], first_err_idx[0]} !== {1'b0, 8'd2, 8'd1})
            $display("FAIL resp_err: got done %b pass %b err %0d idx %0d expected 1 0 2 1", ok, pass[0], err_count[0], first_err_idx[0]);
        else passed++;
    endtask

    task automatic test_timeout();
        int n; bit got; logic aw16, w16;
        do_reset(0);
        wready[0] = 1'b0;
        pulse_start(0, 1'b0);
        n = 0; got = 1'b0; aw16 = 1'bx; w16 = 1'bx;
        while (n < 100 && !got) begin
            if (n == 16) begin aw16 = awvalid[0]; w16 = wvalid[0]; end
            if (done[0]) got = 1'b1;
            else begin @(negedge tb_ACLK); n++; end
        end
        total++;
        if (!got || n != 17) $display("FAIL timeout_latency: got done %b after %0d cycles expected 17", got, n);
        else passed++;
        total++;
        if ({aw16, w16} !== 2'b00) $display("FAIL timeout_valids_fin: got %b expected 00", {aw16, w16}); else passed++;
        total++;
        if ({timeout[0], pass[0], err_count[0]} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL timeout_status: got to %b pass %b err %0d expected 1 0 1", timeout[0], pass[0], err_count[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n; bit ok;
        do_reset(0);
        wready[0] = 1'b0;
        pulse_start(0, 1'b0);
        @(negedge tb_ACLK);
        start[0] = 1'b1; mode[0] = 1'b1;
        @(negedge tb_ACLK);
        start[0] = 1'b0; mode[0] = 1'b0;
        @(negedge tb_ACLK);
        wready[0] = 1'b1; rstall[0] = 1'b1;
        ok = 1'b0; n = 0;
        while (n < 50 && !ok) begin
            if (rready[0]) ok = 1'b1;
            else begin @(negedge tb_ACLK); n++; end
        end
        total++; if (!ok) $display("FAIL b2b_reach_rd_data: RREADY not seen within 50 cycles"); else passed++;
        total++;
        if (aw_cnt[0] !== 1 || w_cnt[0] !== 1) $display("FAIL b2b_single_aw_w: got aw %0d w %0d expected 1 1", aw_cnt[0], w_cnt[0]);
        else passed++;
        total++;
        if (aw_at_ar[0] !== 1 || busy[0] !== 1'b1) $display("FAIL b2b_ignored_start: got aw_before_ar %0d busy %b expected 1 1", aw_at_ar[0], busy[0]);
        else passed++;
        areset[0] = 1'b1;
        @(negedge tb_ACLK);
        total++;
        if (outs(0) !== 25'h0) $display("FAIL b2b_midsweep_reset: got %h expected 0", outs(0)); else passed++;
        areset[0] = 1'b0;
        do_reset(0);
        pulse_start(0, 1'b0);
        wait_done(0, n, ok);
        total++;
        if (!ok || pass[0] !== 1'b1) $display("FAIL b2b_recovery: got done %b pass %b expected 1 1", ok, pass[0]);
        else passed++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            areset[k] = 1'b1; start[k] = 1'b0; mode[k] = 1'b0;
            awready[k] = 1'b1; wready[k] = 1'b1; arready[k] = 1'b1; rstall[k] = 1'b0;
            berr_idx[k] = -1; rerr_idx[k] = -1; corrupt_idx[k] = -1; corrupt_mask[k] = '0;
        end
        repeat (3) @(negedge tb_ACLK);
        areset[0] = 1'b0; areset[1] = 1'b0;
        @(negedge tb_ACLK);
        test_reset();
        test_basic();
        test_corrupt();
        test_mode1();
        test_resp_err();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
